pif_wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the single EFB Wishbone port (8-bit address/data) between requesters.
- Master 0 is the I2C slave sequencer. Master 1 is the configuration/UFM sequencer (CFG_* registers 0x70-0x75).
- Sits between the sequencers and the EFB instance, clocked on xclk.
- Grants whole Wishbone cycles (cyc-framed) with round-robin fairness.

---
 rtl/pif_wb_pkg.sv | 44 ++++
 rtl/pif_wb_if.sv | 20 ++
 rtl/pif_wb_rr_pick.sv | 21 ++
 rtl/pif_wb_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pif_wb_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pif_wb_pkg.sv
// -----------------------------------------------------------------------------
// pif_wb_pkg
// Shared definitions for the EFB Wishbone arbiter and the sequencers that use
// it: arbiter state encoding, Wishbone widths and EFB register addresses.
// The I2C and configuration sequencers both address the EFB through the
// arbiter, so the register map lives here rather than in either sequencer.
// -----------------------------------------------------------------------------
package pif_wb_pkg;

    localparam int WB_ADR_W = 8;
    localparam int WB_DAT_W = 8;

    // ERR and DRAIN are only reachable when PIF_WB_TIMEOUT_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT0  = 3'd1,
        ST_GNT1  = 3'd2,
        ST_ERR   = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    // Primary I2C block
    localparam logic [7:0] I2C1_CR    = 8'h40;
    localparam logic [7:0] I2C1_CMDR  = 8'h41;
    localparam logic [7:0] I2C1_TXDR  = 8'h44;
    localparam logic [7:0] I2C1_SR    = 8'h45;
    localparam logic [7:0] I2C1_RXDR  = 8'h47;

    // Secondary I2C block
    localparam logic [7:0] I2C2_CR    = 8'h4A;
    localparam logic [7:0] I2C2_CMDR  = 8'h4B;
    localparam logic [7:0] I2C2_TXDR  = 8'h4E;
    localparam logic [7:0] I2C2_SR    = 8'h4F;
    localparam logic [7:0] I2C2_RXDR  = 8'h51;

    // Configuration / UFM access
    localparam logic [7:0] CFG_CR     = 8'h70;
    localparam logic [7:0] CFG_TXDR   = 8'h71;
    localparam logic [7:0] CFG_SR     = 8'h72;
    localparam logic [7:0] CFG_RXDR   = 8'h73;
    localparam logic [7:0] CFG_IRQ    = 8'h74;
    localparam logic [7:0] CFG_IRQEN  = 8'h75;

endpackage

// File: rtl/pif_wb_if.sv
// -----------------------------------------------------------------------------
// pif_wb_if
// 8-bit Wishbone bundle. "master" is the side that starts cycles (drives
// cyc/stb/we/adr/dat_w), "slave" is the side that answers (drives dat_r/ack).
// Signals: cyc, stb, we, adr[7:0], dat_w[7:0], dat_r[7:0], ack.
// -----------------------------------------------------------------------------
interface pif_wb_if;

    logic                              cyc;
    logic                              stb;
    logic                              we;
    logic [pif_wb_pkg::WB_ADR_W-1:0]   adr;
    logic [pif_wb_pkg::WB_DAT_W-1:0]   dat_w;
    logic [pif_wb_pkg::WB_DAT_W-1:0]   dat_r;
    logic                              ack;

    modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
    modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);

endinterface

// File: rtl/pif_wb_rr_pick.sv
// -----------------------------------------------------------------------------
// pif_wb_rr_pick
// Combinational two-way round-robin picker.
//   req_i[1:0]  request vector (bit x = master x wants the bus)
//   last_i      index of the master served most recently
//   valid_o     at least one request present
//   winner_o    index of the master to grant
// A lone requester always wins; on a tie the master that was not served last
// wins.
// -----------------------------------------------------------------------------
module pif_wb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    assign valid_o  = |req_i;
    assign winner_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/pif_wb_arbiter.sv
// -----------------------------------------------------------------------------
// pif_wb_arbiter
// Shares the single EFB Wishbone port between the I2C slave sequencer (m0)
// and the configuration/UFM sequencer (m1). Whole cyc-framed cycles are
// granted round-robin; the grant is registered, so a request reaches the EFB
// one cycle after cyc rises and there is always one idle bus cycle between
// grants.
//
// Ports:
//   xclk      system clock, rising edge
//   sys_rst   asynchronous active-low reset
//   m0, m1    master-side Wishbone buses (arbiter acts as their slave)
//   s         EFB-side Wishbone bus (arbiter acts as its master)
//   m0_err    one-cycle timeout error pulse to master 0
//   m1_err    one-cycle timeout error pulse to master 1
//   gnt       one-hot current grant, 00 when nobody owns the bus
//
// Optional feature: define PIF_WB_TIMEOUT_EN to abort a granted strobe that
// waits TIMEOUT_CYCLES without ack (ERR pulse, then DRAIN until the offender
// drops cyc). Without it the error outputs are tied low.
// -----------------------------------------------------------------------------
module pif_wb_arbiter
    import pif_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_BITS        = 7
) (
    input  logic        xclk,
    input  logic        sys_rst,
    pif_wb_if.slave     m0,
    pif_wb_if.slave     m1,
    pif_wb_if.master    s,
    output logic        m0_err,
    output logic        m1_err,
    output logic [1:0]  gnt
);

    if (2 ** TO_BITS <= TIMEOUT_CYCLES) begin : g_bad_to_bits
        $error("TO_BITS too small for TIMEOUT_CYCLES");
    end

    arb_state_e  state_q;
    logic        last_q;
    logic [1:0]  gnt_q;

    logic        pick_valid;
    logic        pick_winner;
    logic        own_idx;
    logic        own_cyc;

`ifdef PIF_WB_TIMEOUT_EN
    localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT_CYCLES - 1);
    logic [TO_BITS-1:0] to_cnt_q;
    logic               owner_q;
    logic [1:0]         err_q;

    // owner_q keeps the offender identity through ERR/DRAIN.
    assign own_idx = owner_q;
`else
    assign own_idx = (state_q == ST_GNT1);
`endif

    assign own_cyc = own_idx ? m1.cyc : m0.cyc;

    pif_wb_rr_pick u_pick (
        .req_i    ({m1.cyc, m0.cyc}),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .winner_o (pick_winner)
    );

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 2'b00;
            last_q   <= 1'b1;
`ifdef PIF_WB_TIMEOUT_EN
            to_cnt_q <= '0;
            owner_q  <= 1'b0;
            err_q    <= 2'b00;
`endif
        end else begin
`ifdef PIF_WB_TIMEOUT_EN
            err_q <= 2'b00;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_q <= pick_winner ? ST_GNT1 : ST_GNT0;
                        gnt_q   <= pick_winner ? 2'b10 : 2'b01;
`ifdef PIF_WB_TIMEOUT_EN
                        owner_q  <= pick_winner;
                        to_cnt_q <= '0;
`endif
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (!own_cyc) begin
                        // Release, including abandon-before-ack.
                        state_q <= ST_IDLE;
                        gnt_q   <= 2'b00;
                        last_q  <= own_idx;
`ifdef PIF_WB_TIMEOUT_EN
                        to_cnt_q <= '0;
                    end else if (s.ack) begin
                        to_cnt_q <= '0;
                    end else if (s.stb) begin
                        if (to_cnt_q == TO_LIMIT) begin
                            state_q  <= ST_ERR;
                            gnt_q    <= 2'b00;
                            err_q    <= own_idx ? 2'b10 : 2'b01;
                            to_cnt_q <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
`endif
                    end
                end
`ifdef PIF_WB_TIMEOUT_EN
                ST_ERR: begin
                    state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Keep the bus closed until the offender ends its frame.
                    if (!own_cyc) begin
                        state_q <= ST_IDLE;
                        last_q  <= owner_q;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // EFB-side bus follows the granted master; quiet in every other state so
    // an asynchronous reset drops s.cyc without waiting for a clock.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.adr   = '0;
        s.dat_w = '0;
        case (state_q)
            ST_GNT0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.adr   = m0.adr;
                s.dat_w = m0.dat_w;
            end
            ST_GNT1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.adr   = m1.adr;
                s.dat_w = m1.dat_w;
            end
            default: ;
        endcase
    end

    assign m0.ack   = s.ack & (state_q == ST_GNT0);
    assign m1.ack   = s.ack & (state_q == ST_GNT1);
    assign m0.dat_r = (state_q == ST_GNT0) ? s.dat_r : '0;
    assign m1.dat_r = (state_q == ST_GNT1) ? s.dat_r : '0;
    assign gnt      = gnt_q;

`ifdef PIF_WB_TIMEOUT_EN
    assign m0_err = err_q[0];
    assign m1_err = err_q[1];
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_pif_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pif_wb_arbiter
// Directed bench for pif_wb_arbiter. A bus-ownership model (who owns the bus,
// who was served last, how long the current strobe has waited) predicts every
// output each cycle; directed scenarios add hand-computed expectations.
// Build with PIF_WB_TIMEOUT_EN defined to include the timeout scenario.
// -----------------------------------------------------------------------------
module tb_pif_wb_arbiter;
    import pif_wb_pkg::*;

    localparam int TO_CYC = 8;

    logic       xclk    = 1'b0;
    logic       sys_rst = 1'b0;
    logic       m0_err, m1_err;
    logic [1:0] gnt;

    always #5 xclk = ~xclk;

    pif_wb_if m0_if ();
    pif_wb_if m1_if ();
    pif_wb_if s_if ();

    pif_wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC), .TO_BITS(7)) dut (
        .xclk    (xclk),
        .sys_rst (sys_rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .m0_err  (m0_err),
        .m1_err  (m1_err),
        .gnt     (gnt)
    );

    // Master stimulus, indexed by master number.
    logic       mc [2];
    logic       ms [2];
    logic       mw [2];
    logic [7:0] ma [2];
    logic [7:0] md [2];

    assign m0_if.cyc = mc[0];  assign m0_if.stb = ms[0];  assign m0_if.we = mw[0];
    assign m0_if.adr = ma[0];  assign m0_if.dat_w = md[0];
    assign m1_if.cyc = mc[1];  assign m1_if.stb = ms[1];  assign m1_if.we = mw[1];
    assign m1_if.adr = ma[1];  assign m1_if.dat_w = md[1];

    // EFB responder: acks each strobe in its second cycle.
    logic       efb_ack  = 1'b0;
    logic [7:0] efb_dat  = 8'h00;
    logic [7:0] efb_rdat = 8'h00;
    bit         efb_auto = 1'b1;
    int         efb_cnt  = 0;

    assign s_if.ack   = efb_ack;
    assign s_if.dat_r = efb_dat;

    always @(posedge xclk) begin
        #2;
        if (!efb_auto) begin
            efb_ack = 1'b0;
            efb_cnt = 0;
        end else if (efb_ack) begin
            efb_ack = 1'b0;
            efb_cnt = 0;
        end else if (s_if.stb) begin
            if (efb_cnt == 1) begin
                efb_ack = 1'b1;
                efb_dat = efb_rdat;
            end else begin
                efb_cnt++;
            end
        end else begin
            efb_cnt = 0;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%02h required=%02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- ownership model ----------------
    // own: -1 nobody, else master index. phase: 0 normal, 1 error pulse,
    // 2 waiting for the offender to drop cyc.
    int own    = -1;
    int lastm  = 1;
    int phase  = 0;
    int errown = 0;
    int waited = 0;

    always @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            own = -1; lastm = 1; phase = 0; waited = 0;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            if (!mc[errown]) begin
                phase = 0;
                lastm = errown;
            end
        end else if (own < 0) begin
            if (mc[0] && mc[1]) own = 1 - lastm;
            else if (mc[0])     own = 0;
            else if (mc[1])     own = 1;
            waited = 0;
        end else if (!mc[own]) begin
            lastm = own;
            own   = -1;
        end else begin
`ifdef PIF_WB_TIMEOUT_EN
            if (efb_ack) waited = 0;
            else if (ms[own]) begin
                waited++;
                if (waited == TO_CYC) begin
                    phase  = 1;
                    errown = own;
                    own    = -1;
                end
            end
`endif
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         dut_log [$];
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge xclk) begin : cmp
        logic g0, g1;
        if (sys_rst) begin
            g0 = (phase == 0) && (own == 0);
            g1 = (phase == 0) && (own == 1);
            check8("cmp_gnt",   8'(gnt), 8'({g1, g0}));
            check1("cmp_s_cyc", s_if.cyc, g0 ? mc[0] : (g1 ? mc[1] : 1'b0));
            check1("cmp_s_stb", s_if.stb, g0 ? ms[0] : (g1 ? ms[1] : 1'b0));
            check1("cmp_s_we",  s_if.we,  g0 ? mw[0] : (g1 ? mw[1] : 1'b0));
            check8("cmp_s_adr", s_if.adr, g0 ? ma[0] : (g1 ? ma[1] : 8'h00));
            check8("cmp_s_dat_w", s_if.dat_w, g0 ? md[0] : (g1 ? md[1] : 8'h00));
            check1("cmp_m0_ack", m0_if.ack, g0 & efb_ack);
            check1("cmp_m1_ack", m1_if.ack, g1 & efb_ack);
            check8("cmp_m0_dat_r", m0_if.dat_r, g0 ? efb_dat : 8'h00);
            check8("cmp_m1_dat_r", m1_if.dat_r, g1 ? efb_dat : 8'h00);
            check1("cmp_m0_err", m0_err, (phase == 1) && (errown == 0));
            check1("cmp_m1_err", m1_err, (phase == 1) && (errown == 1));
            if (m0_if.ack)
                $display("txn m0 adr=%02h we=%0b wdat=%02h rdat=%02h", ma[0], mw[0], md[0], m0_if.dat_r);
            if (m1_if.ack)
                $display("txn m1 adr=%02h we=%0b wdat=%02h rdat=%02h", ma[1], mw[1], md[1], m1_if.dat_r);
            if (prev_gnt == 2'b00 && gnt != 2'b00)
                dut_log.push_back(gnt[1]);
        end
        prev_gnt = gnt;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    task automatic set_m(input int x, input logic c, input logic s, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
        mc[x] = c; ms[x] = s; mw[x] = w; ma[x] = a; md[x] = d;
    endtask

    task automatic rst_pulse();
        tick();
        sys_rst = 1'b0;
        tick();
        sys_rst = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input int x);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge xclk);
            if ((x == 0) ? m0_if.ack : m1_if.ack) begin
                ok = 1'b1;
                break;
            end
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_ack_m%0d: actual=no ack required=ack within 20 cycles", x);
        end
    endtask

    task automatic wait_any(output int who);
        who = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge xclk);
            if (m0_if.ack) begin who = 0; break; end
            if (m1_if.ack) begin who = 1; break; end
        end
        n_assert++;
        if (who < 0) begin
            n_fail++;
            $display("FAIL wait_any_ack: actual=no ack required=ack within 20 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        int base;
        for (int i = 0; i < 2; i++) set_m(i, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset state
        repeat (2) @(negedge xclk);
        check8("rst_gnt", 8'(gnt), 8'h00);
        check1("rst_s_cyc", s_if.cyc, 1'b0);
        check1("rst_s_stb", s_if.stb, 1'b0);
        check8("rst_s_adr", s_if.adr, 8'h00);
        check1("rst_m0_ack", m0_if.ack, 1'b0);
        check8("rst_m0_dat_r", m0_if.dat_r, 8'h00);
        check1("rst_m1_err", m1_err, 1'b0);
        tick();
        sys_rst = 1'b1;

        // Single master read of I2C1_SR, EFB returns 0xC4
        tick();
        efb_rdat = 8'hC4;
        set_m(0, 1'b1, 1'b1, 1'b0, I2C1_SR, 8'h00);
        @(negedge xclk);
        check8("t1_gnt_latency", 8'(gnt), 8'h00);
        check1("t1_s_cyc_latency", s_if.cyc, 1'b0);
        @(negedge xclk);
        check8("t1_s_adr", s_if.adr, 8'h45);
        check8("t1_gnt", 8'(gnt), 8'h01);
        @(negedge xclk);
        check1("t1_m0_ack", m0_if.ack, 1'b1);
        check8("t1_m0_dat_r", m0_if.dat_r, 8'hC4);
        check1("t1_m1_ack", m1_if.ack, 1'b0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Simultaneous request straight out of reset
        rst_pulse();
        set_m(0, 1'b1, 1'b1, 1'b1, I2C1_TXDR, 8'hA5);
        set_m(1, 1'b1, 1'b1, 1'b0, CFG_SR, 8'h00);
        @(negedge xclk);
        @(negedge xclk);
        check8("t2_first_gnt", 8'(gnt), 8'h01);
        wait_ack(0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge xclk);
        check1("t2_drop_s_cyc", s_if.cyc, 1'b0);
        @(negedge xclk);
        check8("t2_idle_gap", 8'(gnt), 8'h00);
        @(negedge xclk);
        check8("t2_second_gnt", 8'(gnt), 8'h02);
        wait_ack(1);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Continuous contention: four write frames
        rst_pulse();
        base = dut_log.size();
        set_m(0, 1'b1, 1'b1, 1'b1, I2C1_TXDR, 8'h5A);
        set_m(1, 1'b1, 1'b1, 1'b1, CFG_TXDR, 8'h12);
        for (int f = 0; f < 4; f++) begin
            wait_any(who);
            if (who >= 0) begin
                check8("t3_s_dat_w", s_if.dat_w, (who == 0) ? 8'h5A : 8'h12);
                tick();
                mc[who] = 1'b0; ms[who] = 1'b0;
                tick();
                if (f < 2) begin
                    mc[who] = 1'b1; ms[who] = 1'b1;
                end
            end
        end
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        n_assert++;
        if (dut_log.size() < base + 4) begin
            n_fail++;
            $display("FAIL t3_frames: actual=%0d grants required=4", dut_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++)
                check1("t3_grant_order", dut_log[base + i], (i % 2) == 1);
        end

        // m1 holds cyc over three strobes while m0 waits
        rst_pulse();
        set_m(1, 1'b1, 1'b1, 1'b0, CFG_CR, 8'h00);
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, I2C1_SR, 8'h00);
        wait_ack(1);
        check8("t4_hold_gnt_a", 8'(gnt), 8'h02);
        tick();
        ma[1] = CFG_SR;
        wait_ack(1);
        check8("t4_hold_gnt_b", 8'(gnt), 8'h02);
        tick();
        ma[1] = CFG_RXDR;
        wait_ack(1);
        check8("t4_hold_gnt_c", 8'(gnt), 8'h02);
        check8("t4_adr_c", s_if.adr, 8'h73);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge xclk);
        check8("t4_release_gnt", 8'(gnt), 8'h02);
        check1("t4_m0_ack", m0_if.ack, 1'b0);
        @(negedge xclk);
        check8("t4_idle_gap", 8'(gnt), 8'h00);
        @(negedge xclk);
        check8("t4_m0_gnt", 8'(gnt), 8'h01);
        wait_ack(0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // Early abandon: m0 drops cyc with no ack
        efb_auto = 1'b0;
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, I2C1_RXDR, 8'h00);
        @(negedge xclk);
        @(negedge xclk);
        check8("t5_gnt", 8'(gnt), 8'h01);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge xclk);
        @(negedge xclk);
        check8("t5_abandon_gnt", 8'(gnt), 8'h00);
        check1("t5_abandon_ack", m0_if.ack, 1'b0);
        check1("t5_abandon_err", m0_err, 1'b0);

        // Asynchronous reset in the middle of a write
        tick();
        set_m(1, 1'b1, 1'b1, 1'b1, CFG_TXDR, 8'h3C);
        @(negedge xclk);
        @(negedge xclk);
        check1("t5_pre_s_cyc", s_if.cyc, 1'b1);
        @(posedge xclk);
        #3;
        sys_rst = 1'b0;
        #1;
        check1("t5_async_s_cyc", s_if.cyc, 1'b0);
        check8("t5_async_gnt", 8'(gnt), 8'h00);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        sys_rst = 1'b1;
        efb_auto = 1'b1;
        tick();

`ifdef PIF_WB_TIMEOUT_EN
        // EFB never acks m1: error after TO_CYC strobe cycles
        rst_pulse();
        efb_auto = 1'b0;
        set_m(1, 1'b1, 1'b1, 1'b0, CFG_IRQEN, 8'h00);
        @(negedge xclk);
        for (int k = 0; k < TO_CYC; k++) begin
            @(negedge xclk);
            if (k == 0) check8("t6_gnt", 8'(gnt), 8'h02);
            check1("t6_no_err_yet", m1_err, 1'b0);
        end
        @(negedge xclk);
        check1("t6_m1_err", m1_err, 1'b1);
        check1("t6_err_s_cyc", s_if.cyc, 1'b0);
        check8("t6_err_gnt", 8'(gnt), 8'h00);
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, I2C1_SR, 8'h00);
        @(negedge xclk);
        check1("t6_err_pulse_end", m1_err, 1'b0);
        check8("t6_drain_gnt", 8'(gnt), 8'h00);
        @(negedge xclk);
        @(negedge xclk);
        check8("t6_drain_hold", 8'(gnt), 8'h00);
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        efb_auto = 1'b1;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge xclk);
                if (gnt == 2'b01) begin got = 1'b1; break; end
            end
            check1("t6_m0_served", got, 1'b1);
        end
        wait_ack(0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
